// File: rtl/cdc_pkg.sv
// Shared definitions for the four-phase req/ack crossing: the sender FSM states
// and the default synchroniser depth, used by both the sender and the receiver.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam int SYNC_FF_DEFAULT = 2;

endpackage

// File: rtl/cdc_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level; the chain clears to 0 on reset.
module cdc_bit_sync
  import cdc_pkg::*;
#(
  parameter int SYNC_FF = SYNC_FF_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_FF-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_FF-2:0], d};
    end
  end

  assign q = chain[SYNC_FF-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side sender of the four-phase req/ack handshake: captures a word, raises
// req_out, and holds the word until the synchronised acknowledge has risen and fallen.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_FF     = SYNC_FF_DEFAULT,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              xfer_done,
  output logic              err_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam bit               TIMER_EN    = (TIMEOUT_CYC != 0);

  state_t           state;
  logic             ack_s;
  logic             accept;
  logic             advance;
  logic             busy;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  cdc_bit_sync #(
    .SYNC_FF(SYNC_FF)
  ) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d    (ack_in),
    .q    (ack_s)
  );

  // A stale acknowledge seen in IDLE (destination not yet reset) blocks new words.
  assign in_ready = (state == IDLE) && !ack_s;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign cnt_sat  = (cnt == '1);
  assign cnt_inc  = cnt + CNT_W'(1);

  always_comb begin
    advance = 1'b0;
    case (state)
      IDLE:     advance = accept;
      REQ:      advance = ack_s;
      WAIT_LOW: advance = !ack_s;
      default:  advance = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_out     <= 1'b0;
      data_out    <= '0;
      xfer_done   <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      xfer_done <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            data_out <= in_data;
            req_out  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_out <= 1'b0;
            state   <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!ack_s) begin
            xfer_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_out <= 1'b0;
          state   <= IDLE;
        end
      endcase

      // The timer only flags a stalled partner; the handshake keeps waiting regardless.
      if (advance) begin
        cnt <= '0;
      end else if (busy && !cnt_sat) begin
        cnt <= cnt_inc;
        if (TIMER_EN && (cnt_inc == TIMEOUT_VAL)) begin
          err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: single transfer, back-pressure, coinciding
// done/accept, a randomly delayed responder, timeout and reset mid-transfer.
module tb_cdc_handshake_tx;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_in;
  logic       xfer_done;
  logic       err_timeout;

  int nvec;
  int nerr;
  int acc_cnt;
  int xfer_cnt;
  int bad_hold;
  logic [7:0] words [100];

  cdc_handshake_tx #(
    .DATA_W     (8),
    .SYNC_FF    (2),
    .TIMEOUT_CYC(16),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .req_out    (req_out),
    .data_out   (data_out),
    .ack_in     (ack_in),
    .xfer_done  (xfer_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advances one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
    if (acc) acc_cnt++;
    if (xfer_done) xfer_cnt++;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    in_valid = valid;
    in_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nvec++;
    assert (observed === expected)
    else begin
      nerr++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic holdCheck(input logic [7:0] word);
    if (req_out && (data_out !== word)) bad_hold++;
  endtask

  // Drives ack_in high after d1 cycles, low d2 cycles after req_out falls;
  // returns in the cycle where xfer_done is high.
  task automatic handshake(input logic [7:0] word, input int d1, input int d2);
    int k;
    for (k = 0; k < d1; k++) begin
      tick();
      holdCheck(word);
    end
    ack_in = 1'b1;
    k = 0;
    while (req_out && k < 20) begin
      tick();
      holdCheck(word);
      k++;
    end
    checkOutput("req_fall", 32'(req_out), 32'(0));
    repeat (d2) tick();
    ack_in = 1'b0;
    k = 0;
    while (!xfer_done && k < 20) begin
      tick();
      k++;
    end
    checkOutput("xfer_done", 32'(xfer_done), 32'(1));
  endtask

  initial begin
    int  x0;
    int  a0;
    bit  ok;

    clk      = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ack_in   = 1'b0;
    nvec     = 0;
    nerr     = 0;
    acc_cnt  = 0;
    xfer_cnt = 0;
    bad_hold = 0;

    repeat (3) tick();
    reset = 1'b0;
    $display("[TB] reset values");
    checkOutput("rst_req", 32'(req_out), 32'(0));
    checkOutput("rst_data", 32'(data_out), 32'(0));
    checkOutput("rst_xfer", 32'(xfer_done), 32'(0));
    checkOutput("rst_err", 32'(err_timeout), 32'(0));
    checkOutput("rst_ready", 32'(in_ready), 32'(1));

    $display("[TB] single transfer");
    applyStimulus(1'b1, 8'hA5);
    checkOutput("t1_ready_t0", 32'(in_ready), 32'(1));
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_req_t1", 32'(req_out), 32'(1));
    checkOutput("t1_data_t1", 32'(data_out), 32'hA5);
    checkOutput("t1_ready_t1", 32'(in_ready), 32'(0));
    repeat (3) tick();
    ack_in = 1'b1;
    repeat (2) tick();
    checkOutput("t1_req_t6", 32'(req_out), 32'(1));
    tick();
    checkOutput("t1_req_t7", 32'(req_out), 32'(0));
    repeat (3) tick();
    ack_in = 1'b0;
    repeat (2) tick();
    checkOutput("t1_xfer_t12", 32'(xfer_done), 32'(0));
    checkOutput("t1_ready_t12", 32'(in_ready), 32'(0));
    tick();
    checkOutput("t1_xfer_t13", 32'(xfer_done), 32'(1));
    checkOutput("t1_ready_t13", 32'(in_ready), 32'(1));
    checkOutput("t1_data_t13", 32'(data_out), 32'hA5);
    tick();
    checkOutput("t1_xfer_t14", 32'(xfer_done), 32'(0));

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b1, 8'h3C);
    acc_cnt = 0;
    checkOutput("t2_req", 32'(req_out), 32'(1));
    checkOutput("t2_data", 32'(data_out), 32'hA5);
    handshake(8'hA5, 3, 3);
    checkOutput("t2_no_early_acc", 32'(acc_cnt), 32'(0));
    checkOutput("t2_data_held", 32'(data_out), 32'hA5);
    checkOutput("t2_ready", 32'(in_ready), 32'(1));
    tick();
    checkOutput("t2_data_3c", 32'(data_out), 32'h3C);
    checkOutput("t2_req_3c", 32'(req_out), 32'(1));
    checkOutput("t2_acc_once", 32'(acc_cnt), 32'(1));

    $display("[TB] done and accept in the same cycle");
    applyStimulus(1'b1, 8'h5A);
    handshake(8'h3C, 2, 4);
    checkOutput("t6_ready", 32'(in_ready), 32'(1));
    checkOutput("t6_acc_before", 32'(acc_cnt), 32'(1));
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("t6_req", 32'(req_out), 32'(1));
    checkOutput("t6_data", 32'(data_out), 32'h5A);
    checkOutput("t6_acc_after", 32'(acc_cnt), 32'(2));
    handshake(8'h5A, 1, 1);
    tick();
    checkOutput("t6_idle_req", 32'(req_out), 32'(0));
    checkOutput("t6_acc_final", 32'(acc_cnt), 32'(2));

    $display("[TB] back-to-back with delayed responder");
    for (int i = 0; i < 100; i++) words[i] = 8'($urandom);
    x0 = xfer_cnt;
    applyStimulus(1'b1, words[0]);
    for (int i = 0; i < 100; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        a0 = acc_cnt;
        tick();
        if (acc_cnt != a0) ok = 1'b1;
      end
      checkOutput("t3_accept", 32'(ok), 32'(1));
      if (i < 99) applyStimulus(1'b1, words[i+1]);
      else        applyStimulus(1'b0, 8'h00);
      checkOutput("t3_word", 32'(data_out), 32'(words[i]));
      handshake(words[i], int'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
    end
    tick();
    checkOutput("t3_xfer_count", 32'(xfer_cnt - x0), 32'(100));
    checkOutput("t3_hold", 32'(bad_hold), 32'(0));

    $display("[TB] timeout");
    applyStimulus(1'b1, 8'h77);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_err_r0", 32'(err_timeout), 32'(0));
    repeat (15) tick();
    checkOutput("t4_err_r15", 32'(err_timeout), 32'(0));
    tick();
    checkOutput("t4_err_r16", 32'(err_timeout), 32'(1));
    checkOutput("t4_req_r16", 32'(req_out), 32'(1));
    handshake(8'h77, 2, 2);
    checkOutput("t4_err_done", 32'(err_timeout), 32'(1));
    repeat (2) tick();
    checkOutput("t4_err_sticky", 32'(err_timeout), 32'(1));

    $display("[TB] reset mid-transfer");
    applyStimulus(1'b1, 8'h11);
    tick();
    applyStimulus(1'b0, 8'h00);
    ack_in = 1'b1;
    for (int k = 0; k < 20 && req_out; k++) tick();
    checkOutput("t5_in_wait_low", 32'(req_out), 32'(0));
    x0 = xfer_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_req", 32'(req_out), 32'(0));
    checkOutput("t5_err", 32'(err_timeout), 32'(0));
    checkOutput("t5_data", 32'(data_out), 32'(0));
    repeat (2) tick();
    checkOutput("t5_ready_guard", 32'(in_ready), 32'(0));
    repeat (2) tick();
    checkOutput("t5_ready_guard2", 32'(in_ready), 32'(0));
    ack_in = 1'b0;
    tick();
    checkOutput("t5_ready_f1", 32'(in_ready), 32'(0));
    tick();
    checkOutput("t5_ready_f2", 32'(in_ready), 32'(1));
    repeat (2) tick();
    checkOutput("t5_no_xfer", 32'(xfer_cnt - x0), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
